// File: rtl/sd_mem_arb_if.sv
// Bundle of client request/grant lines and the shared single-port memory port.
// The arbiter takes the master side; clients and the memory model take the slave side.
interface sd_mem_arb_if #(
  parameter int clients = 4,
  parameter int width   = 8,
  parameter int depth   = 64,
  parameter int asz     = $clog2(depth)
);
  logic [clients-1:0]       c_req;
  logic [clients-1:0]       c_we;
  logic [clients*asz-1:0]   c_addr;
  logic [clients*width-1:0] c_wdata;
  logic [clients-1:0]       c_grant;
  logic [clients-1:0]       c_rvalid;
  logic [width-1:0]         c_rdata;
  logic [asz-1:0]           mem_addr;
  logic                     mem_we;
  logic                     mem_re;
  logic [width-1:0]         mem_wdata;
  logic [width-1:0]         mem_rd_data;

  modport master (
    input  c_req, c_we, c_addr, c_wdata, mem_rd_data,
    output c_grant, c_rvalid, c_rdata, mem_addr, mem_we, mem_re, mem_wdata
  );
  modport slave (
    output c_req, c_we, c_addr, c_wdata, mem_rd_data,
    input  c_grant, c_rvalid, c_rdata, mem_addr, mem_we, mem_re, mem_wdata
  );
endinterface

// File: rtl/sd_mem_arb.sv
// Round-robin arbiter in front of one single-port, 1-cycle-read memory.
// Optional burst grants: define SDLIB_ARB_BURST_EN.
module sd_mem_arb #(
  parameter int clients = 4,
  parameter int width   = 8,
  parameter int depth   = 64,
  parameter int asz     = $clog2(depth),
  parameter int burst   = 4
) (
  input  logic              clk,
  input  logic              reset,
  sd_mem_arb_if.master      bus
);
  localparam int PW = (clients > 1) ? $clog2(clients) : 1;

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [clients-1:0] rvalid_q, rvalid_d;
  logic [PW-1:0]      win;
  logic               any_req, gnt_vld;
  logic [clients-1:0] grant;

`ifdef SDLIB_ARB_BURST_EN
  localparam int BW = (burst > 1) ? $clog2(burst) : 1;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [PW-1:0] last_gnt_q, last_gnt_d;
  logic          last_vld_q, last_vld_d;
  logic          hold;
`endif

  always_comb begin
    int j;
    j       = 0;
    win     = '0;
    any_req = 1'b0;
    for (int k = 0; k < clients; k++) begin
      j = (int'(rr_ptr_q) + k) % clients;
      if (!any_req && bus.c_req[j]) begin
        any_req = 1'b1;
        win     = PW'(j);
      end
    end
`ifdef SDLIB_ARB_BURST_EN
    // A burst only continues from a grant in the immediately preceding cycle.
    hold = last_vld_q && bus.c_req[last_gnt_q] && (burst_cnt_q < BW'(burst - 1));
    if (hold) win = last_gnt_q;
`endif
    gnt_vld = any_req & reset;

    grant    = '0;
    rvalid_d = '0;
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      grant[win] = 1'b1;
      if (!bus.c_we[win]) rvalid_d[win] = 1'b1;
      rr_ptr_d = (int'(win) == clients - 1) ? '0 : win + PW'(1);
    end
`ifdef SDLIB_ARB_BURST_EN
    burst_cnt_d = (gnt_vld && hold) ? burst_cnt_q + BW'(1) : '0;
    last_gnt_d  = gnt_vld ? win : last_gnt_q;
    last_vld_d  = gnt_vld;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      rvalid_q <= '0;
`ifdef SDLIB_ARB_BURST_EN
      burst_cnt_q <= '0;
      last_gnt_q  <= '0;
      last_vld_q  <= 1'b0;
`endif
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
`ifdef SDLIB_ARB_BURST_EN
      burst_cnt_q <= burst_cnt_d;
      last_gnt_q  <= last_gnt_d;
      last_vld_q  <= last_vld_d;
`endif
    end
  end

  assign bus.c_grant   = grant;
  assign bus.mem_we    = gnt_vld &  bus.c_we[win];
  assign bus.mem_re    = gnt_vld & ~bus.c_we[win];
  assign bus.mem_addr  = gnt_vld ? bus.c_addr[int'(win)*asz +: asz] : '0;
  assign bus.mem_wdata = gnt_vld ? bus.c_wdata[int'(win)*width +: width] : '0;
  // Gating by reset drops a read return that lands in the first reset cycle.
  assign bus.c_rvalid  = rvalid_q & {clients{reset}};
  assign bus.c_rdata   = bus.mem_rd_data;
endmodule

// File: tb/tb_sd_mem_arb.sv
// Directed bench for sd_mem_arb with a behavioural 1-cycle-read memory.
module tb_sd_mem_arb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  sd_mem_arb_if #(.clients(4), .width(8), .depth(64)) bus ();
  sd_mem_arb #(.clients(4), .width(8), .depth(64), .burst(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  logic [7:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) rd_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rd_data = rd_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cl(input int i, input logic we, input logic [5:0] a, input logic [7:0] d);
    bus.c_we[i]          = we;
    bus.c_addr[i*6 +: 6] = a;
    bus.c_wdata[i*8 +: 8] = d;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev, exp;
    logic [3:0] skip_exp [3];
    bus.c_req = 4'b1111;
    bus.c_we = '0; bus.c_addr = '0; bus.c_wdata = '0;
    for (int i = 0; i < 4; i++) set_cl(i, 1'b0, 6'(10 + i), 8'h00);

    // reset held with all clients requesting
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_grant", 32'(bus.c_grant), 32'h0);
      chk("rst_we", 32'(bus.mem_we), 32'h0);
      chk("rst_re", 32'(bus.mem_re), 32'h0);
      chk("rst_rvalid", 32'(bus.c_rvalid), 32'h0);
      nxt();
    end
    reset = 1'b1;

    // rotation, all reads
    prev = 4'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp = 4'b0001 << (k % 4);
      chk("rr_grant", 32'(bus.c_grant), 32'(exp));
      chk("rr_rvalid", 32'(bus.c_rvalid), 32'(prev));
      chk("rr_addr", 32'(bus.mem_addr), 32'(10 + k % 4));
      chk("rr_re", 32'(bus.mem_re), 32'h1);
      prev = exp;
      nxt();
    end

    // client 2 writes A5 @7, client 1 reads it back
    bus.c_req = 4'b0100; set_cl(2, 1'b1, 6'd7, 8'hA5);
    @(negedge clk);
    chk("wr_grant", 32'(bus.c_grant), 32'h4);
    chk("wr_we", 32'(bus.mem_we), 32'h1);
    chk("wr_addr", 32'(bus.mem_addr), 32'd7);
    chk("wr_data", 32'(bus.mem_wdata), 32'hA5);
    chk("wr_rvalid", 32'(bus.c_rvalid), 32'h8);
    nxt();
    bus.c_req = 4'b0010; set_cl(1, 1'b0, 6'd7, 8'h00);
    @(negedge clk);
    chk("rd_grant", 32'(bus.c_grant), 32'h2);
    chk("rd_re", 32'(bus.mem_re), 32'h1);
    nxt();
    bus.c_req = 4'b0000;
    @(negedge clk);
    chk("rd_rvalid", 32'(bus.c_rvalid), 32'h2);
    chk("rd_rdata", 32'(bus.c_rdata), 32'hA5);
    chk("idle_grant", 32'(bus.c_grant), 32'h0);
    chk("idle_we", 32'(bus.mem_we), 32'h0);
    chk("idle_addr", 32'(bus.mem_addr), 32'h0);
    nxt();

    // park pointer at 1, idle a cycle, then 1001 skips and wraps
    bus.c_req = 4'b0001;
    @(negedge clk);
    chk("park_grant", 32'(bus.c_grant), 32'h1);
    nxt();
    bus.c_req = 4'b0000;
    nxt();
`ifdef SDLIB_ARB_BURST_EN
    skip_exp = '{4'b1000, 4'b1000, 4'b1000};
`else
    skip_exp = '{4'b1000, 4'b0001, 4'b1000};
`endif
    bus.c_req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("skip_grant", 32'(bus.c_grant), 32'(skip_exp[k]));
      nxt();
    end

    // read granted, reset the next cycle: the return is dropped
    bus.c_req = 4'b0010;
    @(negedge clk);
    chk("mr_grant", 32'(bus.c_grant), 32'h2);
    nxt();
    reset = 1'b0; bus.c_req = 4'b0000;
    @(negedge clk);
    chk("mr_rvalid_rst", 32'(bus.c_rvalid), 32'h0);
    chk("mr_grant_rst", 32'(bus.c_grant), 32'h0);
    nxt();
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rvalid_post", 32'(bus.c_rvalid), 32'h0);
    nxt();

    // two steady requesters
    bus.c_req = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
`ifdef SDLIB_ARB_BURST_EN
      exp = (k < 4 || k >= 8) ? 4'b0001 : 4'b0010;
`else
      exp = (k % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
      chk("pair_grant", 32'(bus.c_grant), 32'(exp));
      nxt();
    end
    bus.c_req = 4'b0000;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
